// File: rtl/sort_job_arbiter.sv
// sort_job_arbiter
// Shares one bubble-sort engine between two requesters. A grant covers a whole
// job: N_ELEMS puts from the owning requester, then N_ELEMS gets routed back to
// that same requester. Ownership alternates round-robin between jobs.
//
// Optional build macro: SORT_ARB_ORDER_CHECK_EN
//   defined   -> signed order checker on drained words drives a sticky sort_err
//   undefined -> sort_err tied to 0, no comparator or previous-word register
//
// Ports
//   CLK, RST_N             clock; synchronous active-high reset (despite the name)
//   req0_*/req1_*          client input channels (valid/data/ready)
//   rsp0_*/rsp1_*          client result channels (valid/data/ready)
//   srt_put_x, srt_EN_put, srt_RDY_put   sorter put side
//   srt_get, srt_EN_get, srt_RDY_get     sorter get side
//   busy                   arbiter is in a job (state != IDLE)
//   owner                  current or last granted requester
//   jobs_done              completed job counter, wraps
//   sort_err               sticky order violation flag
//
// The handshake outputs (ready/valid/EN) are combinational from the registered
// state and the live sorter/client flags; busy, owner, jobs_done and sort_err
// come straight from registers.
module sort_job_arbiter #(
  parameter int unsigned N_ELEMS = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,

  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,

  output logic [DATA_W-1:0] srt_put_x,
  output logic              srt_EN_put,
  input  logic              srt_RDY_put,
  input  logic [DATA_W-1:0] srt_get,
  output logic              srt_EN_get,
  input  logic              srt_RDY_get,

  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  jobs_done,
  output logic              sort_err
);

  localparam int unsigned IDX_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   jobs_q, jobs_d;

  logic               grant;
  logic               own_req_valid;
  logic               own_rsp_ready;
  logic               get_fire;

  // State register; RST_N is an active-high synchronous reset here.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      jobs_q   <= jobs_d;
    end
  end

  // Next-state and handshake routing.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    jobs_d     = jobs_q;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    srt_EN_put = 1'b0;
    srt_EN_get = 1'b0;
    get_fire   = 1'b0;

    own_req_valid = owner_q ? req1_valid : req0_valid;
    own_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    // Put data always follows the owner mux; only meaningful with srt_EN_put.
    srt_put_x     = owner_q ? req1_data : req0_data;

    case (state_q)
      IDLE: begin
        // Single requester wins outright; a tie goes to the round-robin pointer.
        if (req0_valid || req1_valid) begin
          grant   = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
          owner_d = grant;
          state_d = LOAD;
        end
      end

      LOAD: begin
        // Ready mirrors sorter space only; it must not look at valid.
        if (owner_q) req1_ready = srt_RDY_put;
        else         req0_ready = srt_RDY_put;
        srt_EN_put = own_req_valid & srt_RDY_put;
        if (srt_EN_put) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end

      DRAIN: begin
        if (owner_q) rsp1_valid = srt_RDY_get;
        else         rsp0_valid = srt_RDY_get;
        srt_EN_get = srt_RDY_get & own_rsp_ready;
        get_fire   = srt_EN_get;
        if (srt_EN_get) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d    = '0;
            state_d  = IDLE;
            rr_ptr_d = ~owner_q;
            jobs_d   = jobs_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Both result channels see the sorter word; only the owner's valid is raised.
  assign rsp0_data = srt_get;
  assign rsp1_data = srt_get;

  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign jobs_done = jobs_q;

`ifdef SORT_ARB_ORDER_CHECK_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              sort_err_q, sort_err_d;

  // Compare each drained word after the first of a job with its predecessor.
  always_comb begin
    prev_d     = prev_q;
    sort_err_d = sort_err_q;
    if (get_fire) begin
      prev_d = srt_get;
      if ((cnt_q != '0) && ($signed(srt_get) < $signed(prev_q))) begin
        sort_err_d = 1'b1;
      end
    end
  end

  // Order checker registers; the error flag is sticky until reset.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      prev_q     <= '0;
      sort_err_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      sort_err_q <= sort_err_d;
    end
  end

  assign sort_err = sort_err_q;
`else
  assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Randomised bench for sort_job_arbiter with a transaction-level reference
// model: requester word queues, a queue-based sorter model, and per-job result
// checks against a sorted copy of the words the owner sent.
module tb_sort_job_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          CLK, RST_N;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] req0_data, rsp0_data, req1_data, rsp1_data;
  logic [DW-1:0] srt_put_x, srt_get;
  logic          srt_EN_put, srt_RDY_put, srt_EN_get, srt_RDY_get;
  logic          busy, owner, sort_err;
  logic [CW-1:0] jobs_done;

  sort_job_arbiter #(.N_ELEMS(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .srt_put_x(srt_put_x), .srt_EN_put(srt_EN_put), .srt_RDY_put(srt_RDY_put),
    .srt_get(srt_get), .srt_EN_get(srt_EN_get), .srt_RDY_get(srt_RDY_get),
    .busy(busy), .owner(owner), .jobs_done(jobs_done), .sort_err(sort_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef enum int {M_IDLE, M_LOAD, M_DRAIN} mst_t;
  mst_t m_state;
  bit   m_owner, m_rr, m_err;
  int   m_cnt, m_jobs, m_prev;
  int   pend0[$], pend1[$];
  int   s_buf[$], s_out[$];
  int   job_in[$], got[$], last_got[$];
  int   grant_log[$];
  bit   bad_mode, hold0, rsp_low1;
  int   p_valid, p_put, p_get, p_rsp;
  int   busy_cycles;

  task automatic model_reset();
    m_state = M_IDLE; m_owner = 0; m_rr = 0; m_err = 0;
    m_cnt = 0; m_jobs = 0; m_prev = 0;
    pend0.delete(); pend1.delete(); s_buf.delete(); s_out.delete();
    job_in.delete(); got.delete();
    hold0 = 0; rsp_low1 = 0;
  endtask

  task automatic push_job(input int req);
    for (int k = 0; k < N; k++) begin
      if (req == 0) pend0.push_back(int'($urandom));
      else          pend1.push_back(int'($urandom));
    end
  endtask

  // One clock: drive, check combinational routing, advance model, check registers.
  task automatic tick();
    bit e_r0, e_r1, e_put, e_get, e_v0, e_v1, granted;
    int obs, w, g;
    int e[$];
    req0_valid  = !hold0 && pend0.size() > 0 && ($urandom_range(99) < p_valid);
    req0_data   = pend0.size() > 0 ? DW'(pend0[0]) : DW'($urandom);
    req1_valid  = pend1.size() > 0 && ($urandom_range(99) < p_valid);
    req1_data   = pend1.size() > 0 ? DW'(pend1[0]) : DW'($urandom);
    rsp0_ready  = $urandom_range(99) < p_rsp;
    rsp1_ready  = !rsp_low1 && ($urandom_range(99) < p_rsp);
    srt_RDY_put = s_out.size() == 0 && s_buf.size() < N && ($urandom_range(99) < p_put);
    srt_RDY_get = s_out.size() > 0 && ($urandom_range(99) < p_get);
    srt_get     = s_out.size() > 0 ? DW'(s_out[0]) : DW'($urandom);
    #1;
    e_r0  = m_state == M_LOAD && !m_owner && srt_RDY_put;
    e_r1  = m_state == M_LOAD &&  m_owner && srt_RDY_put;
    e_put = m_state == M_LOAD && (m_owner ? req1_valid : req0_valid) && srt_RDY_put;
    e_get = m_state == M_DRAIN && srt_RDY_get && (m_owner ? rsp1_ready : rsp0_ready);
    e_v0  = m_state == M_DRAIN && !m_owner && srt_RDY_get;
    e_v1  = m_state == M_DRAIN &&  m_owner && srt_RDY_get;
    check("handshake", {req0_ready, req1_ready, srt_EN_put, srt_EN_get, rsp0_valid, rsp1_valid},
          {e_r0, e_r1, e_put, e_get, e_v0, e_v1});
    if (e_put) check("put_data", srt_put_x, m_owner ? req1_data : req0_data);
    obs = int'(m_owner ? rsp1_data : rsp0_data);
    if (e_get) check("rsp_data", DW'(obs), DW'(s_out[0]));
    granted = 0;
    @(posedge CLK);
    case (m_state)
      M_IDLE: if (req0_valid || req1_valid) begin
        g = (req0_valid && req1_valid) ? int'(m_rr) : int'(req1_valid);
        m_owner = g[0]; m_state = M_LOAD; granted = 1;
        job_in.delete(); got.delete();
      end
      M_LOAD: if (e_put) begin
        w = m_owner ? pend1.pop_front() : pend0.pop_front();
        job_in.push_back(w); s_buf.push_back(w);
        m_cnt++;
        if (m_cnt == N) begin m_cnt = 0; m_state = M_DRAIN; end
        if (s_buf.size() == N) begin
          if (bad_mode) s_out = '{1, 3, 2, 4, 5};
          else begin s_buf.sort(); s_out = s_buf; end
          s_buf.delete();
        end
      end
      M_DRAIN: if (e_get) begin
        w = s_out.pop_front();
        got.push_back(obs);
`ifdef SORT_ARB_ORDER_CHECK_EN
        if (m_cnt > 0 && w < m_prev) m_err = 1;
`endif
        m_prev = w;
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0; m_state = M_IDLE; m_rr = !m_owner; m_jobs++;
          if (!bad_mode) begin
            e = job_in; e.sort();
            for (int k = 0; k < N; k++) check("job_word", DW'(got[k]), DW'(e[k]));
          end
          last_got = got;
        end
      end
      default: ;
    endcase
    #1;
    check("regs", {busy, owner, jobs_done, sort_err},
          {m_state != M_IDLE, m_owner, CW'(m_jobs), m_err});
    if (busy) busy_cycles++;
    if (granted) grant_log.push_back(int'(owner));
  endtask

  task automatic do_reset();
    RST_N = 1'b1;
    @(posedge CLK);
    model_reset();
    #1;
    RST_N = 1'b0;
    check("reset_regs", {busy, owner, jobs_done, sort_err}, '0);
    check("reset_en", {srt_EN_put, srt_EN_get, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, '0);
  endtask

  task automatic run_jobs(input int target, input int budget);
    int n = 0;
    while (m_jobs < target && n < budget) begin tick(); n++; end
    if (m_jobs < target) check("job_timeout", 64'(jobs_done), 64'(target));
  endtask

  task automatic run_to(input mst_t st, input int cnt, input int budget);
    int n = 0;
    while (!(m_state == st && m_cnt == cnt) && n < budget) begin tick(); n++; end
    if (n >= budget) check("state_timeout", 64'(busy), 64'(st != M_IDLE) + 64'h100);
  endtask

  initial begin
    int exp1[$];
    int bad[$];
    bit e_err;
    exp1 = '{1, 2, 3, 4, 5};
    bad  = '{1, 3, 2, 4, 5};
    RST_N = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    rsp0_ready = 0; rsp1_ready = 0; srt_RDY_put = 0; srt_RDY_get = 0; srt_get = '0;
    bad_mode = 0;
    p_valid = 100; p_put = 100; p_get = 100; p_rsp = 100;
    repeat (2) @(posedge CLK);
    do_reset();

    // Single job from requester 0 at full speed
    pend0 = '{5, 3, 1, 4, 2};
    busy_cycles = 0;
    grant_log.delete();
    run_jobs(1, 100);
    for (int k = 0; k < N; k++) check("t1_word", DW'(last_got[k]), DW'(exp1[k]));
    check("t1_owner", 64'(grant_log[0]), 64'd0);
    check("t1_busy_cycles", 64'(busy_cycles), 64'(2 * N));

    // Both requesters always valid: grants alternate from reset
    do_reset();
    grant_log.delete();
    push_job(0); push_job(0); push_job(1); push_job(1);
    run_jobs(4, 200);
    for (int k = 0; k < 4; k++) check("t2_grant", 64'(grant_log[k]), 64'(k % 2));

    // Requester 1 result channel stalls after the 2nd word
    push_job(1);
    run_to(M_DRAIN, 2, 100);
    rsp_low1 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_en_get", srt_EN_get, 1'b0);
    end
    rsp_low1 = 0;
    run_jobs(5, 100);

    // Owner 0 pauses mid-load while requester 1 waits
    grant_log.delete();
    push_job(0); push_job(1);
    run_to(M_LOAD, 2, 100);
    hold0 = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_blocked", {req1_ready, owner}, 2'b00);
    end
    hold0 = 0;
    run_jobs(7, 200);
    check("t4_grant0", 64'(grant_log[0]), 64'd0);
    check("t4_grant1", 64'(grant_log[1]), 64'd1);

    // Reset in the middle of a drain, with the round-robin pointer at 1
    push_job(0);
    run_jobs(8, 100);
    push_job(1);
    run_to(M_DRAIN, 2, 100);
    do_reset();
    grant_log.delete();
    push_job(0); push_job(1);
    run_jobs(1, 100);
    check("t5_grant_after_rst", 64'(grant_log[0]), 64'd0);

    // Sorter misorders its output
    do_reset();
    bad_mode = 1;
    push_job(0);
    run_jobs(1, 100);
    for (int k = 0; k < N; k++) check("t6_word", DW'(last_got[k]), DW'(bad[k]));
    e_err = 0;
`ifdef SORT_ARB_ORDER_CHECK_EN
    e_err = 1;
`endif
    check("t6_sort_err", sort_err, e_err);
    bad_mode = 0;
    push_job(1);
    run_jobs(2, 100);
    check("t6_sort_err_sticky", sort_err, e_err);

    // Random traffic with stalls everywhere
    do_reset();
    p_valid = 70; p_put = 65; p_get = 60; p_rsp = 70;
    for (int j = 0; j < 30; j++) begin
      if (pend0.size() == 0 && $urandom_range(1) == 1) push_job(0);
      if (pend1.size() == 0 && $urandom_range(1) == 1) push_job(1);
      if (pend0.size() == 0 && pend1.size() == 0) push_job(int'($urandom_range(1)));
      run_jobs(m_jobs + 1, 400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
